// File: rtl/tsm_sbox_sequencer_pkg.sv
// Shared definitions for the time-shared two-share PRINCE S-box sequencer.
// Holds the FSM state encoding, the share and randomness widths, and the
// field offsets inside the PRNG word (rnd_data).
package tsm_sbox_pkg;

    localparam int NIB_W        = 4;
    localparam int RAND_W       = 14;
    localparam int COMP_W       = 4;
    localparam int RND_W        = RAND_W + COMP_W;
    localparam int RND_BIT_LSB  = 4;
    localparam int RND_COMP_LSB = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        PH0    = 3'd2,
        FETCH1 = 3'd3,
        PH1    = 3'd4,
        COMB   = 3'd5,
        OUT    = 3'd6
    } state_e;

endpackage

// File: rtl/tsm_sbox_sequencer_if.sv
// Handshake bundle for the S-box sequencer: input shares, PRNG word and
// result handshake.
//   master : upstream/PRNG/downstream side (drives valids, data, out_ready)
//   slave  : the sequencer (drives in_ready, rnd_ready, out_valid)
interface tsm_sbox_sequencer_if;
    import tsm_sbox_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [NIB_W-1:0] in_share1;
    logic [NIB_W-1:0] in_share2;

    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd_data;

    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, in_share1, in_share2, rnd_valid, rnd_data, out_ready,
        input  in_ready, rnd_ready, out_valid
    );

    modport slave (
        input  in_valid, in_share1, in_share2, rnd_valid, rnd_data, out_ready,
        output in_ready, rnd_ready, out_valid
    );

endinterface

// File: rtl/tsm_sbox_sequencer_phase_mux.sv
// Zero-forcing share/randomness mux feeding the shared cross-product datapath.
// Ports:
//   sel_ph0_i / sel_ph1_i : phase selects (never both high)
//   sh1_i / sh2_i         : registered shares
//   rnd_i                 : registered PRNG word
//   sb_share_o, sb_rand_bit_o, sb_rand_comp_o : gated datapath inputs
// Written as AND-OR gating rather than a priority mux so that outside a phase
// every output bit is a constant 0 and the two shares never meet on one net.
module tsm_phase_mux
    import tsm_sbox_pkg::*;
(
    input  logic              sel_ph0_i,
    input  logic              sel_ph1_i,
    input  logic [NIB_W-1:0]  sh1_i,
    input  logic [NIB_W-1:0]  sh2_i,
    input  logic [RND_W-1:0]  rnd_i,
    output logic [NIB_W-1:0]  sb_share_o,
    output logic [RAND_W-1:0] sb_rand_bit_o,
    output logic [COMP_W-1:0] sb_rand_comp_o
);

    logic [RND_W-1:0] rnd_gated;

    assign sb_share_o     = ({NIB_W{sel_ph0_i}} & sh1_i) | ({NIB_W{sel_ph1_i}} & sh2_i);
    assign rnd_gated      = {RND_W{sel_ph0_i | sel_ph1_i}} & rnd_i;
    assign sb_rand_bit_o  = rnd_gated[RND_BIT_LSB +: RAND_W];
    assign sb_rand_comp_o = rnd_gated[RND_COMP_LSB +: COMP_W];

endmodule

// File: rtl/tsm_sbox_sequencer.sv
// Control/sequencing for the time-shared two-share PRINCE S-box.
// Accepts one masked nibble per handshake, presents share 1 then share 2 to
// the datapath with a fresh PRNG word per phase, triggers recombination and
// hands the result off through out_valid/out_ready.
// Ports:
//   clk, rst_n (sync, active-low), flush (sync abort)
//   bus       : in/rnd/out handshakes (slave modport)
//   sb_*      : share and randomness presented to the datapath
//   cap0_en, cap1_en, comb_en : datapath capture/recombine strobes
//   busy      : state != IDLE
//   op_cnt    : completed operations, wraps at 2^16
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for input shares
// FETCH0 | waiting for PRNG word for phase 0
// PH0    | share 1 on datapath, cap0_en
// FETCH1 | waiting for PRNG word for phase 1
// PH1    | share 2 on datapath, cap1_en
// COMB   | recombination, comb_en
// OUT    | result valid, waiting for out_ready
module tsm_sbox_sequencer
    import tsm_sbox_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    tsm_sbox_sequencer_if.slave  bus,
    output logic [NIB_W-1:0]     sb_share,
    output logic [RAND_W-1:0]    sb_rand_bit,
    output logic [COMP_W-1:0]    sb_rand_comp,
    output logic                 cap0_en,
    output logic                 cap1_en,
    output logic                 comb_en,
    output logic                 busy,
    output logic [15:0]          op_cnt
);

    state_e           state_q;
    logic [NIB_W-1:0] sh1_q;
    logic [NIB_W-1:0] sh2_q;
    logic [RND_W-1:0] rnd_q;
    logic [15:0]      op_cnt_q;
    logic [15:0]      op_cnt_d;

    logic out_hs;
    logic accept;

    assign out_hs       = (state_q == OUT) & bus.out_ready;
    // OUT with out_ready counts as free so back-to-back ops have no bubble.
    assign bus.in_ready = ~flush & ((state_q == IDLE) | out_hs);
    assign accept       = bus.in_valid & bus.in_ready;
    assign op_cnt_d     = op_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh1_q    <= '0;
            sh2_q    <= '0;
            rnd_q    <= '0;
            op_cnt_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            sh1_q   <= '0;
            sh2_q   <= '0;
            rnd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sh1_q   <= bus.in_share1;
                        sh2_q   <= bus.in_share2;
                        state_q <= FETCH0;
                    end
                end
                FETCH0: begin
                    if (bus.rnd_valid) begin
                        rnd_q   <= bus.rnd_data;
                        state_q <= PH0;
                    end
                end
                PH0:    state_q <= FETCH1;
                FETCH1: begin
                    if (bus.rnd_valid) begin
                        rnd_q   <= bus.rnd_data;
                        state_q <= PH1;
                    end
                end
                PH1:    state_q <= COMB;
                COMB:   state_q <= OUT;
                OUT: begin
                    if (bus.out_ready) begin
                        op_cnt_q <= op_cnt_d;
                        if (accept) begin
                            sh1_q   <= bus.in_share1;
                            sh2_q   <= bus.in_share2;
                            state_q <= FETCH0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rnd_ready = (state_q == FETCH0) | (state_q == FETCH1);
    assign bus.out_valid = (state_q == OUT);
    assign cap0_en       = (state_q == PH0);
    assign cap1_en       = (state_q == PH1);
    assign comb_en       = (state_q == COMB);
    assign busy          = (state_q != IDLE);
    assign op_cnt        = op_cnt_q;

    tsm_phase_mux u_phase_mux (
        .sel_ph0_i      (cap0_en),
        .sel_ph1_i      (cap1_en),
        .sh1_i          (sh1_q),
        .sh2_i          (sh2_q),
        .rnd_i          (rnd_q),
        .sb_share_o     (sb_share),
        .sb_rand_bit_o  (sb_rand_bit),
        .sb_rand_comp_o (sb_rand_comp)
    );

endmodule

// File: tb/tb_tsm_sbox_sequencer.sv
module tb_tsm_sbox_sequencer;
    import tsm_sbox_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [NIB_W-1:0]  sb_share;
    logic [RAND_W-1:0] sb_rand_bit;
    logic [COMP_W-1:0] sb_rand_comp;
    logic              cap0_en, cap1_en, comb_en, busy;
    logic [15:0]       op_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    tsm_sbox_sequencer_if bus ();

    tsm_sbox_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .sb_share     (sb_share),
        .sb_rand_bit  (sb_rand_bit),
        .sb_rand_comp (sb_rand_comp),
        .cap0_en      (cap0_en),
        .cap1_en      (cap1_en),
        .comb_en      (comb_en),
        .busy         (busy),
        .op_cnt       (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Invariants during the random run, plus a reference count of handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            assert ($onehot0({cap0_en, cap1_en, comb_en})) else begin
                n_err++;
                $error("FAIL onehot_en: observed %b expected one-hot-or-zero", {cap0_en, cap1_en, comb_en});
            end
            n_cmp++;
            assert ((sb_share == '0) || cap0_en || cap1_en) else begin
                n_err++;
                $error("FAIL share_gate: observed sb_share %0h outside PH0/PH1 expected 0", sb_share);
            end
            if (bus.out_valid && bus.out_ready && !flush)
                exp_cnt = exp_cnt + 16'd1;
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_share1 = '0; bus.in_share2 = '0;
        bus.rnd_valid = 1'b0; bus.rnd_data = '0; bus.out_ready = 1'b1;

        // reset
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_rnd_ready", bus.rnd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_enables", {cap0_en, cap1_en, comb_en}, 0);
        chk("rst_sb", {sb_share, sb_rand_bit, sb_rand_comp}, 0);
        chk("rst_op_cnt", op_cnt, 0);

        // basic op, shares A/5, PRNG 2AAAA then 15555, rnd_valid held high
        bus.in_valid = 1'b1; bus.in_share1 = 4'hA; bus.in_share2 = 4'h5;
        bus.rnd_valid = 1'b1; bus.rnd_data = 18'h2AAAA;
        step();                                   // cycle 1: FETCH0
        bus.in_valid = 1'b0;
        chk("c1_busy", busy, 1);
        chk("c1_rnd_ready", bus.rnd_ready, 1);
        chk("c1_sb_share", sb_share, 0);
        chk("c1_in_ready", bus.in_ready, 0);
        step();                                   // cycle 2: PH0
        chk("c2_cap0", cap0_en, 1);
        chk("c2_share", sb_share, 4'hA);
        chk("c2_rand_bit", sb_rand_bit, 14'h2AAA);
        chk("c2_rand_comp", sb_rand_comp, 4'hA);
        chk("c2_rnd_ready", bus.rnd_ready, 0);
        bus.rnd_data = 18'h15555;
        step();                                   // cycle 3: FETCH1
        chk("c3_share", sb_share, 0);
        chk("c3_rand_bit", sb_rand_bit, 0);
        chk("c3_cap0", cap0_en, 0);
        step();                                   // cycle 4: PH1
        chk("c4_cap1", cap1_en, 1);
        chk("c4_share", sb_share, 4'h5);
        chk("c4_rand_bit", sb_rand_bit, 14'h1555);
        chk("c4_rand_comp", sb_rand_comp, 4'h5);
        step();                                   // cycle 5: COMB
        chk("c5_comb", comb_en, 1);
        chk("c5_out_valid", bus.out_valid, 0);
        chk("c5_share", sb_share, 0);
        step();                                   // cycle 6: OUT
        chk("c6_out_valid", bus.out_valid, 1);
        chk("c6_in_ready", bus.in_ready, 1);
        step();                                   // IDLE
        chk("c7_out_valid", bus.out_valid, 0);
        chk("c7_op_cnt", op_cnt, 1);
        chk("c7_busy", busy, 0);

        // PRNG stall of 3 cycles in FETCH1, shares 3/C
        bus.in_valid = 1'b1; bus.in_share1 = 4'h3; bus.in_share2 = 4'hC;
        bus.rnd_data = 18'h12345;
        step();                                   // 1: FETCH0
        bus.in_valid = 1'b0;
        step();                                   // 2: PH0
        chk("w2_share", sb_share, 4'h3);
        chk("w2_rand_bit", sb_rand_bit, 14'h1234);
        bus.rnd_valid = 1'b0; bus.rnd_data = 18'h3FFFF;
        for (int i = 0; i < 4; i++) begin         // 3..6: FETCH1
            step();
            chk("wait_share", sb_share, 0);
            chk("wait_rnd_ready", bus.rnd_ready, 1);
            chk("wait_cap1", cap1_en, 0);
        end
        bus.rnd_valid = 1'b1; bus.rnd_data = 18'h0ABCD;
        step();                                   // 7: PH1
        chk("w7_share", sb_share, 4'hC);
        chk("w7_rand_bit", sb_rand_bit, 14'h0ABC);
        chk("w7_rand_comp", sb_rand_comp, 4'hD);
        bus.out_ready = 1'b0;
        step();                                   // 8: COMB
        chk("w8_out_valid", bus.out_valid, 0);
        step();                                   // 9: OUT
        // out_ready held low for 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            step();
        end
        chk("hold_op_cnt", op_cnt, 1);
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_share1 = 4'h6; bus.in_share2 = 4'h9;
        #1;
        chk("b2b_out_valid", bus.out_valid, 1);
        chk("b2b_in_ready", bus.in_ready, 1);
        step();                                   // FETCH0 of new op
        bus.in_valid = 1'b0;
        chk("b2b_op_cnt", op_cnt, 2);
        chk("b2b_out_valid_drop", bus.out_valid, 0);
        chk("b2b_rnd_ready", bus.rnd_ready, 1);
        step();                                   // PH0
        chk("b2b_share1", sb_share, 4'h6);
        step();                                   // FETCH1
        step();                                   // PH1
        chk("b2b_share2", sb_share, 4'h9);
        chk("b2b_cap1", cap1_en, 1);

        // flush in PH1, with a coinciding input that must be dropped
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_share1 = 4'h1; bus.in_share2 = 4'h2;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_in_ready_after", bus.in_ready, 1);
        chk("flush_op_cnt", op_cnt, 2);
        chk("flush_share", sb_share, 0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("flush_no_out", bus.out_valid, 0);
            chk("flush_no_busy", busy, 0);
        end

        // reset in COMB
        bus.in_valid = 1'b1; bus.in_share1 = 4'hF; bus.in_share2 = 4'h1;
        step();                                   // FETCH0
        bus.in_valid = 1'b0;
        step(); step(); step();                   // PH0, FETCH1, PH1
        step();                                   // COMB
        chk("rc_comb", comb_en, 1);
        rst_n = 1'b0;
        step();
        chk("rc_busy", busy, 0);
        chk("rc_op_cnt", op_cnt, 0);
        chk("rc_comb_off", comb_en, 0);
        chk("rc_out_valid", bus.out_valid, 0);
        chk("rc_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        step();
        chk("rc_out_valid2", bus.out_valid, 0);
        chk("rc_op_cnt2", op_cnt, 0);

        // random run with invariant monitor and handshake counting
        exp_cnt = 16'd0;
        mon_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_share1 = 4'($urandom_range(0, 15));
            bus.in_share2 = 4'($urandom_range(0, 15));
            bus.rnd_valid = ($urandom_range(0, 3) != 0);
            bus.rnd_data  = 18'($urandom_range(0, 262143));
            bus.out_ready = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 31) == 0);
            step();
        end
        mon_en = 1'b0;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("rand_op_cnt", op_cnt, exp_cnt);
        chk("rand_nonzero_ops", (exp_cnt != 16'd0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tsm_sbox_sequencer.md
# tsm_sbox_sequencer

Control and sequencing block for the time-shared, two-share PRINCE S-box. It accepts one masked nibble per handshake and presents one share at a time to the shared cross-product datapath: share 1 in phase 0, share 2 in phase 1. Each phase gets a freshly drawn randomness word. The block then triggers the recombination stage and returns the result through a valid/ready handshake. It sits between the round-level state register and the S-box datapath.

## Interface
- NIB_W, 4, width of one share
- RAND_W, 14, fresh mask bits per phase (cross-product refresh)
- COMP_W, 4, composable re-mask bits per phase
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, synchronous and active-low
- flush  input  1  synchronous abort of the current operation
- in_valid  input  1  input shares valid
- in_ready  output  1  block can accept input
- in_share1  input  NIB_W  share 1 (bit 4 = x … bit 1 = w)
- in_share2  input  NIB_W  share 2
- rnd_valid  input  1  PRNG word valid
- rnd_ready  output  1  block consumes PRNG word
- rnd_data  input  RAND_W+COMP_W  [17:4] = rand_bit[14:1], [3:0] = composable bits [4:1]
- sb_share  output  NIB_W  share presented to the datapath
- sb_rand_bit  output  RAND_W  refresh bits for the datapath
- sb_rand_comp  output  COMP_W  composable bits for the datapath
- cap0_en  output  1  datapath captures phase-0 products
- cap1_en  output  1  datapath captures phase-1 products
- comb_en  output  1  datapath recombines into output register
- out_valid  output  1  datapath output register holds a result
- out_ready  input  1  downstream accepts the result
- busy  output  1  state ≠ IDLE
- op_cnt  output  16  completed operations, wraps at 2^16

## Operation
- States and transitions:
  - IDLE → FETCH0 on in_valid. Both shares are latched into sh1_q/sh2_q.
  - FETCH0 → PH0 on rnd_valid. rnd_data is latched into rnd_q.
  - PH0 → FETCH1 unconditionally.
  - FETCH1 → PH1 on rnd_valid. rnd_data is latched into rnd_q again, overwriting the phase-0 word.
  - PH1 → COMB.
  - COMB → OUT.
  - OUT → IDLE on out_ready.
- in_ready = (state==IDLE) | (state==OUT & out_ready). When OUT & out_ready & in_valid, the shares are latched and the next state is FETCH0. Back-to-back operation has no bubble at the output side.
- rnd_ready = 1 only in FETCH0/FETCH1. A PRNG word is never used in two phases.
- Phase outputs:
  - In PH0: sb_share = sh1_q, sb_rand_* = rnd_q, cap0_en = 1.
  - In PH1: sb_share = sh2_q, sb_rand_* = rnd_q, cap1_en = 1.
  - In every other state, sb_share, sb_rand_bit and sb_rand_comp are forced to 0. This prevents both shares from reaching the datapath inputs in the same cycle.
- comb_en = 1 only in COMB. out_valid = 1 only in OUT.
- op_cnt increments on each out_valid & out_ready.
- In FETCH0/FETCH1, sh1_q, sh2_q and rnd_q are held while waiting on rnd_valid. There is no timeout.
- flush: next state is IDLE and sh1_q, sh2_q, rnd_q are cleared. op_cnt is unchanged, and the in-flight result is discarded (out_valid drops). Priority: rst_n > flush > FSM. If flush coincides with an in_valid acceptance, the input is dropped; in_ready is forced to 0 while flush = 1.

## Timing
- Reset values:
  - state = IDLE; sh1_q, sh2_q, rnd_q, op_cnt = 0.
  - Outputs: in_ready = 1, rnd_ready = 0, all enables = 0, out_valid = 0, busy = 0, sb_* = 0.
- All outputs decode from registered state and registered data only. No input-to-output combinational path exists except in_ready←out_ready and in_ready←flush.
- Latency with rnd_valid held high: acceptance at cycle 0, FETCH0 at 1, PH0 at 2, FETCH1 at 3, PH1 at 4, COMB at 5, out_valid at 6.
- Each cycle that rnd_valid is low in a FETCH state adds one cycle.
- Throughput: one result per 6 cycles with continuous out_ready.
- Reset mid-operation returns the block to IDLE in one cycle with the reset values above.

## Structure
- Package tsm_sbox_pkg holds:
  - the state enum (IDLE, FETCH0, PH0, FETCH1, PH1, COMB, OUT);
  - localparams NIB_W, RAND_W, COMP_W;
  - the rnd_data field offsets RND_BIT_LSB = 4 and RND_COMP_LSB = 0.
- One sub-module, tsm_phase_mux: the zero-forcing share/randomness mux. It is kept separate so the gating can be inspected for leakage.

## Test plan
- Reset, then in_valid with shares 4'hA/4'h5 and rnd_valid held high → cap0_en at cycle 2 with sb_share = 4'hA; cap1_en at cycle 4 with sb_share = 4'h5; comb_en at 5; out_valid at 6; op_cnt = 1 after the handshake.
- rnd_valid low for 3 cycles in FETCH1 → sb_share = 0 throughout the wait; PH1 uses the word presented when rnd_valid rises; out_valid is delayed by 3 cycles.
- PRNG words 18'h2AAAA then 18'h15555 → in PH0, sb_rand_bit = 14'h2AAA and sb_rand_comp = 4'hA; in PH1, sb_rand_bit = 14'h1555 and sb_rand_comp = 4'h5.
- out_ready low for 5 cycles, then high with in_valid high → out_valid holds for the 5 cycles; the new input is accepted in the same cycle as the output handshake.
- flush asserted in PH1, and in a separate run rst_n low in COMB → next cycle is IDLE, in_ready = 1 (flush deasserted), out_valid never asserts; op_cnt unchanged after flush and 0 after reset.
- Assertion over a random run: cap0_en, cap1_en and comb_en are one-hot or zero; sb_share ≠ 0 only in PH0/PH1.
